alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synthesizable self-checking monitor for the ALU function datapath. It samples operands, carry/borrow inputs and the 3-bit operation select, together with the result and flag produced by the function/overflow muxes. It recomputes the expected values independently, compares them two cycles later and keeps pass/fail statistics plus a capture of the first failing transaction. It sits beside the ALU in simulation and FPGA bring-up builds, as the consuming end of the Sel/operand/result interface.

## Interface
- Width, 3, operand and result width (≥2)
- StopOnFail, 0, 1 = halt checking after the first mismatch until Clear
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Clear  in  1  synchronous clear of counters, capture and halt state
- Valid  in  1  transaction present on the inputs this cycle
- Sel  in  3  operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 rotate-left-by-1, 6 rotate-right-by-1, 7 two's complement of A
- A, B  in  Width  operands
- CIn  in  1  adder carry-in
- BIn  in  1  subtractor borrow-in
- FuncOut  in  Width  ALU result under test
- OverOut  in  1  ALU flag under test
- ChkValid  out  1  one-cycle strobe: a comparison result is on Pass
- Pass  out  1  last compared transaction matched (FuncOut and OverOut)
- CheckCount  out  16  transactions compared, saturating
- ErrCount  out  16  mismatches, saturating
- ErrSticky  out  1  at least one mismatch since reset/Clear
- Halted  out  1  checker in HALT state
- FailSel  out  3  Sel of the first mismatch
- FailA, FailB  out  Width  operands of the first mismatch
- FailGot, FailExp  out  Width+1  {OverOut, FuncOut} received and expected for the first mismatch

## Operation
- Stage 1, capture: when Valid=1 and state is CHECK, register Sel, A, B, CIn, BIn, FuncOut and OverOut, and set v1. Otherwise v1=0.
- Stage 2, compare: when v1=1, compute exp and pulse ChkValid, with Pass = ({OverOut,FuncOut} == exp).
- Expected result per Sel, mod 2^Width:
  - add: A+B+CIn.
  - sub: A−B−BIn.
  - and / or / xor: bitwise.
  - rotl: {A[W-2:0],A[W-1]}.
  - rotr: {A[0],A[W-1:1]}.
  - twos: (~A)+1.
- Expected flag:
  - Sel 0: carry out of the (Width+1)-bit unsigned sum.
  - Sel 1: borrow out, i.e. A < B+BIn unsigned.
  - All other Sel: 0.
- CheckCount increments on every ChkValid. ErrCount increments on every mismatch. Both saturate at 16'hFFFF.
- First-fail capture: the Fail* registers load only on a mismatch while ErrSticky=0. ErrSticky is set in the same cycle as that load.
- State machine, two states:
  - CHECK → HALT on a mismatch when StopOnFail=1.
  - HALT → CHECK on Clear.
  - In HALT, Valid is ignored. Counters and capture are frozen. Halted=1.
- Clear:
  - Zeroes the counters, ErrSticky, the Fail* registers and v1.
  - Forces CHECK.
  - Wins over a same-cycle mismatch or increment; the comparison in that cycle is discarded and no ChkValid is issued.

## Timing
- Latency: Valid sampled at edge n produces ChkValid/Pass valid after edge n+1, i.e. 2 cycles from input presentation to the strobe.
- Throughput is one transaction per cycle. There is no backpressure.
- All outputs are registered.
- Reset values: ChkValid=0, Pass=0, counters=0, ErrSticky=0, Halted=0, all Fail* fields=0, state CHECK, v1=0.
- Reset asserted mid-transaction:
  - Everything clears immediately, asynchronously, including in-flight v1.
  - No ChkValid is produced for the dropped transaction.
- Mismatch that triggers HALT (StopOnFail=1):
  - Its ChkValid still pulses.
  - A transaction already in stage 1 in that cycle is still compared on the next edge and counted.
  - Capture of new transactions stops from the edge at which Halted rises.
- Valid=0 cycles produce no strobe and no count change.

## Test plan
- Width=3, Sel=0, A=5, B=6, CIn=0, FuncOut=3, OverOut=1 → ChkValid 2 cycles later, Pass=1, CheckCount=1, ErrCount=0.
- Sel=1, A=2, B=3, BIn=1, FuncOut=6, OverOut=1 → Pass=1. Then the same transaction with OverOut=0 → Pass=0, ErrSticky=1, FailExp=4'b1110, FailGot=4'b0110.
- Sweep all 8 Sel over A∈{0,3,6}, B∈{0,4}, using correct golden results with an injected mismatch at Sel=5, A=6 (FuncOut=3 instead of 5) → ErrCount=1, FailSel=5, FailA=6, CheckCount=48.
- StopOnFail=1: back-to-back transactions where the 2nd mismatches → Halted rises, the 3rd is still counted, the 4th onward are ignored. Clear → Halted=0, counters=0, checking resumes.
- Clear asserted in the same cycle a mismatch would register → ErrCount stays 0, ErrSticky=0, no ChkValid.
- Rst_n pulsed low mid-stream between clock edges → all outputs 0 immediately. A pending stage-1 transaction never strobes. Force CheckCount to 16'hFFFE and run 3 passes → saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_result_checker.sv
// Two-stage self-checking monitor for the ALU function datapath: captures a transaction,
// recomputes the expected {flag, result} and keeps pass/fail statistics and a first-fail capture.
module alu_result_checker #(
   parameter int unsigned Width      = 3,
   parameter bit          StopOnFail = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic [2:0]       sel_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             cin_i,
   input  logic             bin_i,
   input  logic [Width-1:0] func_out_i,
   input  logic             over_out_i,
   output logic             chk_valid_o,
   output logic             pass_o,
   output logic [15:0]      check_count_o,
   output logic [15:0]      err_count_o,
   output logic             err_sticky_o,
   output logic             halted_o,
   output logic [2:0]       fail_sel_o,
   output logic [Width-1:0] fail_a_o,
   output logic [Width-1:0] fail_b_o,
   output logic [Width:0]   fail_got_o,
   output logic [Width:0]   fail_exp_o
);

   typedef enum logic [0:0] {StCheck, StHalt} state_e;

   localparam logic [Width-1:0] OneW   = Width'(1);
   localparam logic [15:0]      CntMax = 16'hFFFF;

   state_e             state_q, state_d;
   logic               v1_q, v1_d;
   logic [2:0]         sel_q;
   logic [Width-1:0]   a_q, b_q, func_q;
   logic               cin_q, bin_q, over_q;
   logic               cap_en;
   logic               chk_valid_q, chk_valid_d;
   logic               pass_q, pass_d;
   logic [15:0]        check_count_q, check_count_d;
   logic [15:0]        err_count_q, err_count_d;
   logic               err_sticky_q, err_sticky_d;
   logic [2:0]         fail_sel_q, fail_sel_d;
   logic [Width-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d;
   logic [Width:0]     fail_got_q, fail_got_d, fail_exp_q, fail_exp_d;
   logic [Width:0]     sum_w, diff_w, exp_w, got_w;
   logic               mismatch;

   // Stage-1 operand registers only move when a transaction is accepted.
   assign cap_en = valid_i && (state_q == StCheck) && !clear_i;
   assign got_w  = {over_q, func_q};

   always_comb begin
      sum_w  = {1'b0, a_q} + {1'b0, b_q} + {{Width{1'b0}}, cin_q};
      // The top bit of the (Width+1)-bit difference is the borrow out.
      diff_w = {1'b0, a_q} - {1'b0, b_q} - {{Width{1'b0}}, bin_q};
      exp_w  = '0;
      unique case (sel_q)
         3'd0: exp_w = sum_w;
         3'd1: exp_w = diff_w;
         3'd2: exp_w = {1'b0, a_q & b_q};
         3'd3: exp_w = {1'b0, a_q | b_q};
         3'd4: exp_w = {1'b0, a_q ^ b_q};
         3'd5: exp_w = {1'b0, a_q[Width-2:0], a_q[Width-1]};
         3'd6: exp_w = {1'b0, a_q[0], a_q[Width-1:1]};
         3'd7: exp_w = {1'b0, (~a_q) + OneW};
         default: exp_w = '0;
      endcase
   end

   assign mismatch = v1_q && (got_w != exp_w);

   always_comb begin
      state_d       = state_q;
      v1_d          = 1'b0;
      chk_valid_d   = 1'b0;
      pass_d        = pass_q;
      check_count_d = check_count_q;
      err_count_d   = err_count_q;
      err_sticky_d  = err_sticky_q;
      fail_sel_d    = fail_sel_q;
      fail_a_d      = fail_a_q;
      fail_b_d      = fail_b_q;
      fail_got_d    = fail_got_q;
      fail_exp_d    = fail_exp_q;
      if (clear_i) begin
         state_d       = StCheck;
         check_count_d = '0;
         err_count_d   = '0;
         err_sticky_d  = 1'b0;
         fail_sel_d    = '0;
         fail_a_d      = '0;
         fail_b_d      = '0;
         fail_got_d    = '0;
         fail_exp_d    = '0;
      end else begin
         v1_d = cap_en;
         // A transaction already in stage 1 drains even after the halt is taken.
         if (v1_q) begin
            chk_valid_d = 1'b1;
            pass_d      = !mismatch;
            if (check_count_q != CntMax) check_count_d = check_count_q + 16'd1;
            if (mismatch) begin
               if (err_count_q != CntMax) err_count_d = err_count_q + 16'd1;
               if (!err_sticky_q) begin
                  fail_sel_d = sel_q;
                  fail_a_d   = a_q;
                  fail_b_d   = b_q;
                  fail_got_d = got_w;
                  fail_exp_d = exp_w;
               end
               err_sticky_d = 1'b1;
               if (StopOnFail) state_d = StHalt;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StCheck;
         v1_q          <= 1'b0;
         sel_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         cin_q         <= 1'b0;
         bin_q         <= 1'b0;
         func_q        <= '0;
         over_q        <= 1'b0;
         chk_valid_q   <= 1'b0;
         pass_q        <= 1'b0;
         check_count_q <= '0;
         err_count_q   <= '0;
         err_sticky_q  <= 1'b0;
         fail_sel_q    <= '0;
         fail_a_q      <= '0;
         fail_b_q      <= '0;
         fail_got_q    <= '0;
         fail_exp_q    <= '0;
      end else begin
         state_q       <= state_d;
         v1_q          <= v1_d;
         chk_valid_q   <= chk_valid_d;
         pass_q        <= pass_d;
         check_count_q <= check_count_d;
         err_count_q   <= err_count_d;
         err_sticky_q  <= err_sticky_d;
         fail_sel_q    <= fail_sel_d;
         fail_a_q      <= fail_a_d;
         fail_b_q      <= fail_b_d;
         fail_got_q    <= fail_got_d;
         fail_exp_q    <= fail_exp_d;
         if (cap_en) begin
            sel_q  <= sel_i;
            a_q    <= a_i;
            b_q    <= b_i;
            cin_q  <= cin_i;
            bin_q  <= bin_i;
            func_q <= func_out_i;
            over_q <= over_out_i;
         end
      end
   end

   assign chk_valid_o   = chk_valid_q;
   assign pass_o        = pass_q;
   assign check_count_o = check_count_q;
   assign err_count_o   = err_count_q;
   assign err_sticky_o  = err_sticky_q;
   assign halted_o      = (state_q == StHalt);
   assign fail_sel_o    = fail_sel_q;
   assign fail_a_o      = fail_a_q;
   assign fail_b_o      = fail_b_q;
   assign fail_got_o    = fail_got_q;
   assign fail_exp_o    = fail_exp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench: dut0 keeps checking after failures, dut1 halts on the first one.
module tb_alu_result_checker;

   localparam int W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic valid0 = 1'b0, valid1 = 1'b0;
   logic [2:0] sel = '0;
   logic [W-1:0] a = '0, b = '0, fo = '0;
   logic cin = 1'b0, bin = 1'b0, oo = 1'b0;

   logic cv0, pass0, sticky0, halted0, cv1, pass1, sticky1, halted1;
   logic [15:0] cc0, ec0, cc1, ec1;
   logic [2:0] fsel0, fsel1;
   logic [W-1:0] fa0, fb0, fa1, fb1;
   logic [W:0] fgot0, fexp0, fgot1, fexp1;

   typedef struct {int cyc; bit pass;} exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_result_checker #(.Width(W), .StopOnFail(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid0), .sel_i(sel),
      .a_i(a), .b_i(b), .cin_i(cin), .bin_i(bin), .func_out_i(fo), .over_out_i(oo),
      .chk_valid_o(cv0), .pass_o(pass0), .check_count_o(cc0), .err_count_o(ec0),
      .err_sticky_o(sticky0), .halted_o(halted0), .fail_sel_o(fsel0), .fail_a_o(fa0),
      .fail_b_o(fb0), .fail_got_o(fgot0), .fail_exp_o(fexp0)
   );

   alu_result_checker #(.Width(W), .StopOnFail(1'b1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid1), .sel_i(sel),
      .a_i(a), .b_i(b), .cin_i(cin), .bin_i(bin), .func_out_i(fo), .over_out_i(oo),
      .chk_valid_o(cv1), .pass_o(pass1), .check_count_o(cc1), .err_count_o(ec1),
      .err_sticky_o(sticky1), .halted_o(halted1), .fail_sel_o(fsel1), .fail_a_o(fa1),
      .fail_b_o(fb1), .fail_got_o(fgot1), .fail_exp_o(fexp1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected {flag, result} written with integer arithmetic for W=3.
   function automatic logic [3:0] golden(input logic [2:0] s, input logic [2:0] x, y,
                                         input logic ci, bi);
      int t;
      logic [3:0] r;
      r = '0;
      case (s)
         3'd0: begin t = int'(x) + int'(y) + int'(ci); r = {t >= 8, 3'(t)}; end
         3'd1: begin t = int'(x) - int'(y) - int'(bi); r = {t < 0, 3'(t)}; end
         3'd2: r = {1'b0, x & y};
         3'd3: r = {1'b0, x | y};
         3'd4: r = {1'b0, x ^ y};
         3'd5: r = {1'b0, 3'(int'(x) * 2 + int'(x) / 4)};
         3'd6: r = {1'b0, 3'(int'(x) / 2 + (int'(x) % 2) * 4)};
         default: r = {1'b0, 3'(8 - int'(x))};
      endcase
      return r;
   endfunction

   task automatic issue(input int which, input logic [2:0] s, x, y, input logic ci, bi,
                        input logic [2:0] f, input logic o, input bit p, input bit push);
      exp_t e;
      @(posedge clk); #1;
      valid0 = (which == 0);
      valid1 = (which == 1);
      sel = s; a = x; b = y; cin = ci; bin = bi; fo = f; oo = o;
      e.cyc = cyc + 2;
      e.pass = p;
      if (push) begin
         if (which == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         valid0 = 1'b0;
         valid1 = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(posedge clk); #1;
      valid0 = 1'b0;
      valid1 = 1'b0;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && cv0) begin
         if (q0.size() == 0) chk("dut0 unexpected strobe", 32'(cv0), 32'd0);
         else begin
            e = q0.pop_front();
            chk("dut0 strobe cycle", 32'(cyc), 32'(e.cyc));
            chk("dut0 pass", 32'(pass0), 32'(e.pass));
         end
      end
      if (rst_n && cv1) begin
         if (q1.size() == 0) chk("dut1 unexpected strobe", 32'(cv1), 32'd0);
         else begin
            e = q1.pop_front();
            chk("dut1 strobe cycle", 32'(cyc), 32'(e.cyc));
            chk("dut1 pass", 32'(pass1), 32'(e.pass));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int av[3];
      int bv[2];
      logic [3:0] g;
      logic [2:0] x, y;
      av = '{0, 3, 6};
      bv = '{0, 4};

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state
      chk("rst chk_valid", 32'(cv0), 32'd0);
      chk("rst pass", 32'(pass0), 32'd0);
      chk("rst check_count", 32'(cc0), 32'd0);
      chk("rst err_count", 32'(ec0), 32'd0);
      chk("rst sticky", 32'(sticky0), 32'd0);
      chk("rst halted", 32'(halted1), 32'd0);
      chk("rst fail_got", 32'(fgot0), 32'd0);

      // add 5+6+0 = 11 -> 3, carry 1
      issue(0, 3'd0, 3'd5, 3'd6, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1);
      idle(3);
      chk("add check_count", 32'(cc0), 32'd1);
      chk("add err_count", 32'(ec0), 32'd0);

      // sub 2-3-1 = -2 -> 6, borrow 1; then the same with a wrong flag
      issue(0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1);
      issue(0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("sub sticky", 32'(sticky0), 32'd1);
      chk("sub fail_exp", 32'(fexp0), 32'b1110);
      chk("sub fail_got", 32'(fgot0), 32'b0110);
      chk("sub fail_sel", 32'(fsel0), 32'd1);
      chk("sub err_count", 32'(ec0), 32'd1);
      chk("sub check_count", 32'(cc0), 32'd3);

      do_clear();
      chk("clear check_count", 32'(cc0), 32'd0);
      chk("clear sticky", 32'(sticky0), 32'd0);
      chk("clear fail_exp", 32'(fexp0), 32'd0);

      // Sweep with one injected rotl mismatch (6 rotl 1 = 5, driven as 3)
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
               x = 3'(av[i]);
               y = 3'(bv[j]);
               g = golden(3'(s), x, y, x[0], x[1]);
               if (s == 5 && i == 2 && j == 0)
                  issue(0, 3'(s), x, y, x[0], x[1], 3'd3, 1'b0, 1'b0, 1'b1);
               else
                  issue(0, 3'(s), x, y, x[0], x[1], g[2:0], g[3], 1'b1, 1'b1);
            end
         end
      end
      idle(3);
      chk("sweep check_count", 32'(cc0), 32'd48);
      chk("sweep err_count", 32'(ec0), 32'd1);
      chk("sweep fail_sel", 32'(fsel0), 32'd5);
      chk("sweep fail_a", 32'(fa0), 32'd6);
      chk("sweep fail_b", 32'(fb0), 32'd0);
      chk("sweep fail_exp", 32'(fexp0), 32'b0101);
      chk("sweep fail_got", 32'(fgot0), 32'b0011);
      chk("sweep halted no-stop", 32'(halted0), 32'd0);
      do_clear();

      // Clear in the same cycle the mismatch would be compared
      issue(0, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
      do_clear();
      idle(3);
      chk("clrwin err_count", 32'(ec0), 32'd0);
      chk("clrwin sticky", 32'(sticky0), 32'd0);
      chk("clrwin check_count", 32'(cc0), 32'd0);

      // StopOnFail: 2nd mismatches, 3rd drains, 4th/5th ignored
      issue(1, 3'd2, 3'd5, 3'd3, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1);
      issue(1, 3'd4, 3'd5, 3'd3, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
      issue(1, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1);
      issue(1, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
      issue(1, 3'd7, 3'd1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk("halt halted", 32'(halted1), 32'd1);
      chk("halt check_count", 32'(cc1), 32'd3);
      chk("halt err_count", 32'(ec1), 32'd1);
      chk("halt fail_sel", 32'(fsel1), 32'd4);
      chk("halt fail_exp", 32'(fexp1), 32'b0110);
      chk("halt fail_got", 32'(fgot1), 32'b0111);
      do_clear();
      chk("resume halted", 32'(halted1), 32'd0);
      chk("resume check_count", 32'(cc1), 32'd0);
      issue(1, 3'd7, 3'd3, 3'd0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1);
      idle(3);
      chk("resume counted", 32'(cc1), 32'd1);

      // Asynchronous reset with a transaction sitting in stage 1
      issue(0, 3'd3, 3'd4, 3'd1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1);
      idle(2);
      issue(0, 3'd3, 3'd4, 3'd1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #2;
      valid0 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst check_count0", 32'(cc0), 32'd0);
      chk("arst pass0", 32'(pass0), 32'd0);
      chk("arst check_count1", 32'(cc1), 32'd0);
      chk("arst chk_valid0", 32'(cv0), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      idle(4);
      chk("arst no late count", 32'(cc0), 32'd0);

      // Saturation from a preloaded count
      @(negedge clk);
      force u_dut0.check_count_q = 16'hFFFE;
      #1;
      release u_dut0.check_count_q;
      chk("sat preload", 32'(cc0), 32'hFFFE);
      for (int k = 0; k < 3; k++)
         issue(0, 3'd2, 3'd7, 3'(k), 1'b0, 1'b0, 3'(k), 1'b0, 1'b1, 1'b1);
      idle(3);
      chk("sat check_count", 32'(cc0), 32'hFFFF);

      chk("q0 drained", 32'(q0.size()), 32'd0);
      chk("q1 drained", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
